// File: rtl/fault_mon_pkg.sv
// ----------------------------------------------------------------------------
// fault_mon_pkg
// Shared definitions for the multi-channel sensor fault monitor:
//   - ch_state_e : per-channel state encoding (3 bits)
//   - CNT_W      : width of the per-channel retry (trip) counter
//   - DIFF_W     : working width of the absolute-difference helper
//   - abs_diff() : |a - b| computed as larger minus smaller (never wraps)
// ----------------------------------------------------------------------------
package fault_mon_pkg;

    localparam int CNT_W  = 4;
    localparam int DIFF_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MONITOR = 3'd1,
        TRIP    = 3'd2,
        WAIT    = 3'd3,
        LOCKOUT = 3'd4
    } ch_state_e;

    // Operands are zero-extended by the caller; subtracting the smaller from
    // the larger keeps the result exact for unsigned samples.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/fault_channel_fsm.sv
// ----------------------------------------------------------------------------
// fault_channel_fsm
// One monitored channel: compares a sample against its reference, debounces
// the fault, drives the relay for a timed hold, retries, and latches into
// lockout after MAX_RETRY trips until an explicit clear.
// Ports:
//   clk_i        tick clock (rising edge)
//   rst_ni       asynchronous active-low reset
//   enable_i     global enable (does not affect LOCKOUT)
//   sen_i        sensor sample (unsigned)
//   sen_ref_i    reference sample (unsigned)
//   threshold_i  fault threshold; fault when |sen - ref| > threshold
//   clear_i      lockout clear, honoured only in LOCKOUT
//   relay_o      1 = relay open (registered)
//   lockout_o    1 = channel latched failed (registered)
//   retry_cnt_o  trips since the last recovery/clear
// ----------------------------------------------------------------------------
module fault_channel_fsm
    import fault_mon_pkg::*;
#(
    parameter int SEN_W         = 12,
    parameter int THR_W         = 12,
    parameter int DEBOUNCE      = 4,
    parameter int WAIT_TICKS    = 312,
    parameter int MAX_RETRY     = 3,
    parameter int RECOVER_TICKS = 625
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [SEN_W-1:0] sen_i,
    input  logic [SEN_W-1:0] sen_ref_i,
    input  logic [THR_W-1:0] threshold_i,
    input  logic             clear_i,
    output logic             relay_o,
    output logic             lockout_o,
    output logic [CNT_W-1:0] retry_cnt_o
);

    localparam int DBC_W  = $clog2(DEBOUNCE + 1);
    localparam int HOLD_W = $clog2(WAIT_TICKS + 1);
    localparam int REC_W  = $clog2(RECOVER_TICKS + 1);

    localparam logic [DBC_W-1:0]  DBC_MAX   = DBC_W'(DEBOUNCE);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(WAIT_TICKS - 1);
    localparam logic [REC_W-1:0]  REC_MAX   = REC_W'(RECOVER_TICKS);
    localparam logic [CNT_W-1:0]  RETRY_MAX = CNT_W'(MAX_RETRY);

    ch_state_e         state_q, state_d;
    logic [DBC_W-1:0]  dbc_q, dbc_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REC_W-1:0]  rec_q, rec_d;
    logic [CNT_W-1:0]  retry_q, retry_d;
    logic              relay_q, relay_d;
    logic              lockout_q, lockout_d;

    logic [DIFF_W-1:0] diff;
    logic              fail;

    assign diff = abs_diff(DIFF_W'(sen_i), DIFF_W'(sen_ref_i));
    assign fail = diff > DIFF_W'(threshold_i);

    always_comb begin
        state_d = state_q;
        dbc_d   = dbc_q;
        hold_d  = hold_q;
        rec_d   = rec_q;
        retry_d = retry_q;

        if (state_q == LOCKOUT) begin
            // Lockout ignores enable; only an explicit clear releases it.
            if (clear_i) begin
                state_d = IDLE;
                retry_d = '0;
                dbc_d   = '0;
                hold_d  = '0;
                rec_d   = '0;
            end
        end else if (!enable_i) begin
            state_d = IDLE;
            dbc_d   = '0;
            hold_d  = '0;
            rec_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = MONITOR;
                    dbc_d   = '0;
                    rec_d   = '0;
                end
                MONITOR: begin
                    // The trip decision uses the count accumulated so far, so
                    // the relay opens one edge after the debounce count fills.
                    if (dbc_q == DBC_MAX) begin
                        state_d = TRIP;
                        retry_d = retry_q + 1'b1;
                        dbc_d   = '0;
                        rec_d   = '0;
                        hold_d  = '0;
                    end else if (fail) begin
                        dbc_d = dbc_q + 1'b1;
                        rec_d = '0;
                    end else begin
                        dbc_d = '0;
                        if (rec_q != REC_MAX) begin
                            rec_d = rec_q + 1'b1;
                        end
                        if (rec_d == REC_MAX) begin
                            retry_d = '0;
                        end
                    end
                end
                TRIP: begin
                    state_d = WAIT;
                    hold_d  = '0;
                end
                WAIT: begin
                    hold_d = hold_q + 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        dbc_d   = '0;
                        rec_d   = '0;
                        state_d = (retry_q == RETRY_MAX) ? LOCKOUT : MONITOR;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs follow the next state so enable/clear act on the very next tick.
        relay_d   = (state_d == TRIP) || (state_d == WAIT) || (state_d == LOCKOUT);
        lockout_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            dbc_q     <= '0;
            hold_q    <= '0;
            rec_q     <= '0;
            retry_q   <= '0;
            relay_q   <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dbc_q     <= dbc_d;
            hold_q    <= hold_d;
            rec_q     <= rec_d;
            retry_q   <= retry_d;
            relay_q   <= relay_d;
            lockout_q <= lockout_d;
        end
    end

    assign relay_o     = relay_q;
    assign lockout_o   = lockout_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: rtl/multi_channel_fault_monitor.sv
// ----------------------------------------------------------------------------
// multi_channel_fault_monitor
// N_CH independent sensor fault monitors, one relay per channel, ticked by the
// 16 ms system clock.
// Ports:
//   clk_16ms   tick clock (rising edge)
//   rst        asynchronous active-low reset
//   enable     global monitor enable
//   sen        packed samples, channel i at [i*SEN_W +: SEN_W]
//   sen_ref    packed references, same packing
//   threshold  packed thresholds, channel i at [i*THR_W +: THR_W]
//   clear      per-channel lockout clear
//   relay_out  per-channel relay, 1 = open
//   lockout    per-channel latched-fail flag
//   any_fault  registered OR of relay_out (one tick behind)
//   retry_cnt  packed per-channel trip counts, channel i at [i*4 +: 4]
// ----------------------------------------------------------------------------
module multi_channel_fault_monitor
    import fault_mon_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int SEN_W         = 12,
    parameter int THR_W         = 12,
    parameter int DEBOUNCE      = 4,
    parameter int WAIT_TICKS    = 312,
    parameter int MAX_RETRY     = 3,
    parameter int RECOVER_TICKS = 625
) (
    input  logic                    clk_16ms,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_CH*SEN_W-1:0]   sen,
    input  logic [N_CH*SEN_W-1:0]   sen_ref,
    input  logic [N_CH*THR_W-1:0]   threshold,
    input  logic [N_CH-1:0]         clear,
    output logic [N_CH-1:0]         relay_out,
    output logic [N_CH-1:0]         lockout,
    output logic                    any_fault,
    output logic [N_CH*CNT_W-1:0]   retry_cnt
);

    logic any_fault_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        fault_channel_fsm #(
            .SEN_W         (SEN_W),
            .THR_W         (THR_W),
            .DEBOUNCE      (DEBOUNCE),
            .WAIT_TICKS    (WAIT_TICKS),
            .MAX_RETRY     (MAX_RETRY),
            .RECOVER_TICKS (RECOVER_TICKS)
        ) u_ch (
            .clk_i       (clk_16ms),
            .rst_ni      (rst),
            .enable_i    (enable),
            .sen_i       (sen[i*SEN_W +: SEN_W]),
            .sen_ref_i   (sen_ref[i*SEN_W +: SEN_W]),
            .threshold_i (threshold[i*THR_W +: THR_W]),
            .clear_i     (clear[i]),
            .relay_o     (relay_out[i]),
            .lockout_o   (lockout[i]),
            .retry_cnt_o (retry_cnt[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk_16ms or negedge rst) begin
        if (!rst) begin
            any_fault_q <= 1'b0;
        end else begin
            any_fault_q <= |relay_out;
        end
    end

    assign any_fault = any_fault_q;

endmodule

// File: tb/tb_multi_channel_fault_monitor.sv
module tb_multi_channel_fault_monitor;

    localparam int N_CH          = 4;
    localparam int SEN_W         = 12;
    localparam int THR_W         = 12;
    localparam int DEBOUNCE      = 4;
    localparam int WAIT_TICKS    = 312;
    localparam int MAX_RETRY     = 3;
    localparam int RECOVER_TICKS = 625;
    // Edges from first failing sample to lockout under a held fault:
    // each trip cycle = DEBOUNCE+1 edges to open + WAIT_TICKS+1 edges open.
    localparam int CYCLE = DEBOUNCE + 2 + WAIT_TICKS;
    localparam int LOCK_EDGE = MAX_RETRY * CYCLE;

    logic                  clk_16ms = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [N_CH*SEN_W-1:0] sen;
    logic [N_CH*SEN_W-1:0] sen_ref;
    logic [N_CH*THR_W-1:0] threshold;
    logic [N_CH-1:0]       clear;
    logic [N_CH-1:0]       relay_out;
    logic [N_CH-1:0]       lockout;
    logic                  any_fault;
    logic [N_CH*4-1:0]     retry_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk_16ms = ~clk_16ms;

    multi_channel_fault_monitor #(
        .N_CH(N_CH), .SEN_W(SEN_W), .THR_W(THR_W), .DEBOUNCE(DEBOUNCE),
        .WAIT_TICKS(WAIT_TICKS), .MAX_RETRY(MAX_RETRY), .RECOVER_TICKS(RECOVER_TICKS)
    ) dut (
        .clk_16ms  (clk_16ms),
        .rst       (rst),
        .enable    (enable),
        .sen       (sen),
        .sen_ref   (sen_ref),
        .threshold (threshold),
        .clear     (clear),
        .relay_out (relay_out),
        .lockout   (lockout),
        .any_fault (any_fault),
        .retry_cnt (retry_cnt)
    );

    // Stimulus values per channel
    int   s_v [N_CH];
    int   r_v [N_CH];
    int   t_v [N_CH];
    logic clr_v [N_CH];
    logic en_v;

    // Behavioural reference: per channel, whether it is monitoring, the length
    // of the current failing run, the clean streak, trips so far, how many more
    // edges the relay stays open, and whether it is latched.
    int   m_active [N_CH];
    int   m_run    [N_CH];
    int   m_clean  [N_CH];
    int   m_trips  [N_CH];
    int   m_hold   [N_CH];
    int   m_locked [N_CH];
    logic m_any;

    task automatic apply();
        enable = en_v;
        for (int i = 0; i < N_CH; i++) begin
            sen[i*SEN_W +: SEN_W]       = SEN_W'(s_v[i]);
            sen_ref[i*SEN_W +: SEN_W]   = SEN_W'(r_v[i]);
            threshold[i*THR_W +: THR_W] = THR_W'(t_v[i]);
            clear[i]                    = clr_v[i];
        end
    endtask

    function automatic logic [N_CH-1:0] exp_relay();
        logic [N_CH-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[i] = (m_locked[i] != 0) || (m_hold[i] > 0);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_active[i] = 0; m_run[i] = 0; m_clean[i] = 0;
            m_trips[i]  = 0; m_hold[i] = 0; m_locked[i] = 0;
        end
        m_any = 1'b0;
    endtask

    task automatic model_step();
        logic [N_CH-1:0] prev;
        int d;
        bit fl;
        prev = exp_relay();
        for (int i = 0; i < N_CH; i++) begin
            d  = s_v[i] - r_v[i];
            if (d < 0) d = -d;
            fl = d > t_v[i];
            if (m_locked[i] != 0) begin
                if (clr_v[i]) begin
                    m_locked[i] = 0; m_trips[i] = 0; m_active[i] = 0;
                end
            end else if (!en_v) begin
                m_active[i] = 0; m_run[i] = 0; m_clean[i] = 0;
                m_trips[i]  = 0; m_hold[i] = 0;
            end else if (m_active[i] == 0) begin
                m_active[i] = 1; m_run[i] = 0; m_clean[i] = 0;
            end else if (m_hold[i] > 0) begin
                m_hold[i]--;
                if (m_hold[i] == 0) begin
                    if (m_trips[i] == MAX_RETRY) m_locked[i] = 1;
                    m_run[i] = 0; m_clean[i] = 0;
                end
            end else if (m_run[i] == DEBOUNCE) begin
                m_trips[i]++;
                m_hold[i] = WAIT_TICKS + 1;   // trip tick plus the hold window
                m_run[i] = 0; m_clean[i] = 0;
            end else if (fl) begin
                m_run[i]++; m_clean[i] = 0;
            end else begin
                m_run[i] = 0;
                if (m_clean[i] < RECOVER_TICKS) m_clean[i]++;
                if (m_clean[i] == RECOVER_TICKS) m_trips[i] = 0;
            end
        end
        m_any = |prev;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N_CH-1:0]   el;
        logic [N_CH*4-1:0] ec;
        el = '0;
        ec = '0;
        for (int i = 0; i < N_CH; i++) begin
            el[i]        = (m_locked[i] != 0);
            ec[i*4 +: 4] = 4'(m_trips[i]);
        end
        chk("relay_out", 32'(relay_out), 32'(exp_relay()));
        chk("lockout",   32'(lockout),   32'(el));
        chk("retry_cnt", 32'(retry_cnt), 32'(ec));
        chk("any_fault", 32'(any_fault), 32'(m_any));
    endtask

    task automatic tick();
        apply();
        @(posedge clk_16ms);
        if (!rst) model_reset();
        else      model_step();
        #1;
        check_all();
    endtask

    function automatic int pass_val(input int i);
        return r_v[i] - t_v[i] + int'($urandom_range(0, 2 * t_v[i]));
    endfunction

    function automatic int fail_val(input int i);
        int off;
        off = t_v[i] + 1 + int'($urandom_range(0, 150));
        return ($urandom_range(0, 1) != 0) ? r_v[i] + off : r_v[i] - off;
    endfunction

    int   bias [N_CH];

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            r_v[i] = 2000; t_v[i] = 100; s_v[i] = 2000; clr_v[i] = 1'b0;
        end
        en_v = 1'b0;
        rst  = 1'b0;
        apply();
        model_reset();
        repeat (2) @(posedge clk_16ms);
        #1;
        check_all();
        rst = 1'b1;

        // Near-reference samples, including exact-threshold differences
        en_v = 1'b1;
        s_v[0] = 2050;
        for (int k = 0; k < 1000; k++) begin
            if (k >= 500 && k < 600)      s_v[0] = 2100;
            else if (k >= 600 && k < 700) s_v[0] = 1900;
            else if (k >= 700)            s_v[0] = pass_val(0);
            for (int i = 1; i < N_CH; i++) s_v[i] = pass_val(i);
            tick();
        end
        chk("t1_relay0", 32'(relay_out[0]), 32'd0);
        chk("t1_retry0", 32'(retry_cnt[3:0]), 32'd0);

        // Short fail burst is absorbed; held fault trips on the DEBOUNCE+1 edge
        s_v[0] = 2101;
        repeat (DEBOUNCE - 1) tick();
        s_v[0] = 2000;
        tick();
        chk("t2_no_trip", 32'(relay_out[0]), 32'd0);
        s_v[0] = 2101;
        repeat (DEBOUNCE) tick();
        chk("t2_before_rise", 32'(relay_out[0]), 32'd0);
        tick();
        chk("t2_rise", 32'(relay_out[0]), 32'd1);
        chk("t2_retry1", 32'(retry_cnt[3:0]), 32'd1);
        repeat (WAIT_TICKS) tick();
        chk("t2_still_open", 32'(relay_out[0]), 32'd1);
        tick();
        chk("t2_fall", 32'(relay_out[0]), 32'd0);

        // Recovery: RECOVER_TICKS clean ticks clear the retry count
        s_v[0] = 2000;
        repeat (RECOVER_TICKS - 1) tick();
        chk("t4_retry_before", 32'(retry_cnt[3:0]), 32'd1);
        tick();
        chk("t4_retry_cleared", 32'(retry_cnt[3:0]), 32'd0);

        // Under-range fault held until lockout, then cleared
        s_v[0] = 1899;
        repeat (DEBOUNCE + 1) tick();
        chk("t3_retry_after_recover", 32'(retry_cnt[3:0]), 32'd1);
        repeat (LOCK_EDGE - DEBOUNCE - 2) tick();
        chk("t3_not_locked_yet", 32'(lockout[0]), 32'd0);
        tick();
        chk("t3_locked", 32'(lockout[0]), 32'd1);
        chk("t3_relay_held", 32'(relay_out[0]), 32'd1);
        chk("t3_retry_max", 32'(retry_cnt[3:0]), 32'(MAX_RETRY));
        repeat (20) tick();
        en_v = 1'b0;
        repeat (3) tick();
        chk("t3_lock_ignores_enable", 32'(lockout[0]), 32'd1);
        en_v = 1'b1;
        clr_v[0] = 1'b1;
        tick();
        chk("t3_clear_relay", 32'(relay_out[0]), 32'd0);
        chk("t3_clear_lockout", 32'(lockout[0]), 32'd0);
        chk("t3_clear_retry", 32'(retry_cnt[3:0]), 32'd0);
        s_v[0] = 2000;
        tick();
        clr_v[0] = 1'b0;
        repeat (5) tick();

        // Channel isolation and any_fault lag
        s_v[1] = fail_val(1);
        s_v[2] = pass_val(2);
        repeat (DEBOUNCE) tick();
        chk("t5_no_relay_yet", 32'(relay_out), 32'd0);
        tick();
        chk("t5_only_ch1", 32'(relay_out), 32'b0010);
        chk("t5_any_lag", 32'(any_fault), 32'd0);
        tick();
        chk("t5_any_set", 32'(any_fault), 32'd1);

        // Enable drop mid-WAIT
        repeat (10) tick();
        en_v = 1'b0;
        tick();
        chk("t6_enable_drop", 32'(relay_out), 32'd0);
        tick();
        en_v = 1'b1;
        s_v[1] = 2000;
        tick();

        // Async reset during lockout
        s_v[3] = 2000 - 101 - int'($urandom_range(0, 50));
        repeat (LOCK_EDGE) tick();
        chk("t6_ch3_locked", 32'(lockout[3]), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("t6_rst_lockout", 32'(lockout), 32'd0);
        chk("t6_rst_relay", 32'(relay_out), 32'd0);
        tick();
        rst = 1'b1;
        s_v[3] = 2000;
        tick();

        // Randomized phase: random refs/thresholds, persistent fault bias,
        // occasional enable drops and clear pulses
        for (int i = 0; i < N_CH; i++) begin
            r_v[i]  = int'($urandom_range(500, 3500));
            t_v[i]  = int'($urandom_range(0, 300));
            bias[i] = 0;
        end
        for (int k = 0; k < 5000; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 399) == 0) bias[i] = 1 - bias[i];
                if ((bias[i] != 0) == ($urandom_range(0, 9) != 0)) s_v[i] = fail_val(i);
                else                                              s_v[i] = pass_val(i);
                clr_v[i] = ($urandom_range(0, 49) == 0);
            end
            en_v = ($urandom_range(0, 299) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
